// File: rtl/snes_pkg.sv
// snes_pkg: shared types and constants for the SNES pad responder.
// Holds the responder state enum, frame length and standard button bit indices.
package snes_pkg;

   // Responder frame states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits in one standard controller frame
   localparam int SNES_NBITS = 16;

   // Button positions in the serialized word, bit 0 is shifted out first
   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // True while the responder owns a frame (loading or shifting)
   function automatic logic state_is_busy(input state_t s);
      return (s == LOAD) || (s == SHIFT);
   endfunction

endpackage : snes_pkg

// File: rtl/snes_pad_responder_sync_edge.sv
// sync_edge: N-stage synchronizer for an asynchronous pin followed by a
// rise/fall edge detector. RESET_LEVEL lets an idle-high input (the host
// shift clock) come out of reset without producing a spurious edge.
module sync_edge #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync_reg [STAGES];
   logic level_d_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            // First stage samples the raw pin
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_reg[gi] <= RESET_LEVEL;
               else     sync_reg[gi] <= din;
            end
         end else begin : g_rest
            // Later stages resolve metastability
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_reg[gi] <= RESET_LEVEL;
               else     sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   // Delayed copy of the synchronized level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_d_reg <= RESET_LEVEL;
      else     level_d_reg <= sync_reg[STAGES-1];
   end

   assign level = sync_reg[STAGES-1];
   assign rise  = sync_reg[STAGES-1] & ~level_d_reg;
   assign fall  = ~sync_reg[STAGES-1] & level_d_reg;

endmodule : sync_edge

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device side of the SNES controller link. Answers the
// host latch/pulse strobes by shifting out the button word on data
// (active-low), the way a physical pad does.
// Optional feature: define SNES_RESP_TIMEOUT_EN to abort a frame whose host
// stalls for TIMEOUT_CYCLES clk cycles in LOAD or SHIFT.
module snes_pad_responder
   import snes_pkg::*;
#(
   parameter int NBITS          = SNES_NBITS,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             latch,
   input  logic             pulse,
   input  logic [NBITS-1:0] buttons,
   output logic             data,
   output logic             busy,
   output logic             frame_done,
   output logic [4:0]       bit_count
);

   localparam logic [4:0] LAST_IDX = 5'(NBITS - 1);
   localparam logic [4:0] FULL_CNT = 5'(NBITS);

   logic latch_level, latch_rise, latch_fall;
   logic pulse_level, pulse_rise, pulse_fall;

   state_t           state_reg, state_next;
   logic [NBITS-1:0] sr_reg, sr_next;
   logic [4:0]       bit_count_reg, bit_count_next;
   logic             frame_done_reg, frame_done_next;

   // Not every synchronizer output drives logic in every build
   logic unused_edges;
   assign unused_edges = &{1'b0, latch_rise, pulse_level, pulse_fall};

   sync_edge #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (1'b0)
   ) u_latch_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (latch),
      .level (latch_level),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   // The shift clock idles high, so its synchronizer resets high
   sync_edge #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (1'b1)
   ) u_pulse_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (pulse),
      .level (pulse_level),
      .rise  (pulse_rise),
      .fall  (pulse_fall)
   );

`ifdef SNES_RESP_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_reg, tmo_next;
   logic          any_edge;
   logic          tmo_hit;

   assign any_edge = latch_rise | latch_fall | pulse_rise | pulse_fall;
   assign tmo_hit  = state_is_busy(state_reg) && !any_edge && (tmo_reg == TMO_LAST);

   // Idle counter: restarts on any host activity, only runs mid-frame
   always_comb begin
      tmo_next = '0;
      if (!any_edge && state_is_busy(state_reg) && !tmo_hit)
         tmo_next = tmo_reg + 1'b1;
   end

   // Idle counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_reg <= '0;
      else     tmo_reg <= tmo_next;
   end
`else
   logic tmo_hit;
   assign tmo_hit = 1'b0;
`endif

   // Next-state logic: latch dominates everything, then pulse shifting
   always_comb begin
      state_next      = state_reg;
      sr_next         = sr_reg;
      bit_count_next  = bit_count_reg;
      frame_done_next = 1'b0;

      if (latch_level) begin
         // Any latch restarts the frame, abandoning whatever was in flight
         state_next     = LOAD;
         sr_next        = buttons;
         bit_count_next = '0;
      end else begin
         case (state_reg)
            IDLE: ;
            LOAD: begin
               // Leaving LOAD means the latch has just fallen; the register
               // keeps the last word captured while latch was high
               state_next     = SHIFT;
               bit_count_next = '0;
            end
            SHIFT: begin
               if (pulse_rise) begin
                  sr_next = sr_reg >> 1;
                  if (bit_count_reg == LAST_IDX) begin
                     state_next      = DONE;
                     bit_count_next  = FULL_CNT;
                     frame_done_next = 1'b1;
                  end else begin
                     bit_count_next = bit_count_reg + 5'd1;
                  end
               end
            end
            DONE: ;
            default: state_next = IDLE;
         endcase

         if (tmo_hit) begin
            // Stalled host: drop the frame silently
            state_next      = IDLE;
            bit_count_next  = '0;
            frame_done_next = 1'b0;
         end
      end
   end

   // State, shift register, bit counter and done strobe registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         sr_reg         <= '0;
         bit_count_reg  <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sr_reg         <= sr_next;
         bit_count_reg  <= bit_count_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // Output decode from the registered state
   always_comb begin
      data = 1'b1;
      case (state_reg)
         IDLE:    data = 1'b1;
         LOAD:    data = ~buttons[0];
         SHIFT:   data = ~sr_reg[0];
         DONE:    data = 1'b0;
         default: data = 1'b1;
      endcase
   end

   assign busy       = state_is_busy(state_reg);
   assign frame_done = frame_done_reg;
   assign bit_count  = bit_count_reg;

endmodule : snes_pad_responder

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: directed host-side stimulus for snes_pad_responder.
// Acts as the console: latches, clocks out frames and checks the serial word,
// bit counter, busy and frame_done timing against hand-computed values.
module tb_snes_pad_responder;

   localparam int NB   = 16;
   localparam int SS   = 2;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        latch;
   logic        pulse;
   logic [15:0] buttons;
   logic        data;
   logic        busy;
   logic        frame_done;
   logic [4:0]  bit_count;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_count = 0;

   snes_pad_responder #(
      .NBITS          (NB),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .latch      (latch),
      .pulse      (pulse),
      .buttons    (buttons),
      .data       (data),
      .busy       (busy),
      .frame_done (frame_done),
      .bit_count  (bit_count)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) fd_count++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_latch(input int hold);
      latch = 1'b1;
      wait_cyc(hold);
      latch = 1'b0;
      wait_cyc(HALF);
   endtask

   task automatic pulse_n(input int n);
      for (int i = 0; i < n; i++) begin
         pulse = 1'b0;
         wait_cyc(HALF);
         pulse = 1'b1;
         wait_cyc(HALF);
      end
   endtask

   // Clock out a full frame as the host does and compare the sampled word
   task automatic shift_frame(input string tag, input logic [15:0] exp_word);
      logic [15:0] word;
      int          fd_before;
      word      = '0;
      fd_before = fd_count;
      check_eq({tag, "_bc0"}, 32'(bit_count), 32'd0);
      word[0] = data;
      for (int i = 1; i <= NB; i++) begin
         pulse = 1'b0;
         wait_cyc(HALF);
         pulse = 1'b1;
         if (i == NB) begin
            wait_cyc(SS);
            check_eq({tag, "_fd_early"}, 32'(frame_done), 32'd0);
            wait_cyc(1);
            check_eq({tag, "_fd_strobe"}, 32'(frame_done), 32'd1);
            check_eq({tag, "_data_post"}, 32'(data), 32'd0);
            wait_cyc(1);
            check_eq({tag, "_fd_clear"}, 32'(frame_done), 32'd0);
            wait_cyc(HALF - SS - 2);
         end else begin
            wait_cyc(HALF);
         end
         check_eq({tag, "_bc"}, 32'(bit_count), 32'(i));
         if (i < NB) word[i] = data;
      end
      check_eq({tag, "_word"}, 32'(word), 32'(exp_word));
      check_eq({tag, "_data_after"}, 32'(data), 32'd0);
      check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
      check_eq({tag, "_fd_count"}, 32'(fd_count), 32'(fd_before + 1));
      $display("frame %s: buttons=%04h host_word=%04h expected=%04h", tag, buttons, word, exp_word);
   endtask

   initial begin
      int fd_before;
      rst     = 1'b1;
      latch   = 1'b0;
      pulse   = 1'b1;
      buttons = 16'h0000;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(HALF);

      // Reset state
      check_eq("rst_data", 32'(data), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_fd", 32'(frame_done), 32'd0);
      check_eq("rst_bc", 32'(bit_count), 32'd0);
      $display("reset: data=%0b busy=%0b bit_count=%0d", data, busy, bit_count);

      // Pulses with no latch are ignored
      for (int i = 0; i < 3; i++) begin
         pulse_n(1);
         check_eq("idle_pulse_data", 32'(data), 32'd1);
         check_eq("idle_pulse_busy", 32'(busy), 32'd0);
      end
      $display("idle pulses: data=%0b busy=%0b", data, busy);

      // Frame with only B pressed, 12 us latch, busy latency of SS+1 cycles
      buttons = 16'h0001;
      latch   = 1'b1;
      wait_cyc(SS);
      check_eq("busy_latency_early", 32'(busy), 32'd0);
      wait_cyc(1);
      check_eq("busy_latency", 32'(busy), 32'd1);
      check_eq("load_data", 32'(data), 32'd0);
      check_eq("load_bc", 32'(bit_count), 32'd0);
      wait_cyc(600 - SS - 1);
      latch = 1'b0;
      wait_cyc(HALF);
      check_eq("shift_busy", 32'(busy), 32'd1);
      shift_frame("f0001", 16'hFFFE);

      // Mixed pattern
      buttons = 16'hA5C3;
      do_latch(10);
      shift_frame("fA5C3", 16'h5A3C);

      // Buttons change while latched, then again after latch falls
      buttons = 16'h0001;
      latch   = 1'b1;
      wait_cyc(10);
      buttons = 16'h0002;
      wait_cyc(10);
      check_eq("load_live_data", 32'(data), 32'd1);
      latch = 1'b0;
      wait_cyc(HALF);
      buttons = 16'hFFFF;
      wait_cyc(2);
      check_eq("frozen_data", 32'(data), 32'd1);
      shift_frame("f0002", 16'hFFFD);

      // Re-latch after 5 pulses aborts the frame without frame_done
      buttons = 16'hA5C3;
      do_latch(10);
      fd_before = fd_count;
      pulse_n(5);
      check_eq("abort_bc5", 32'(bit_count), 32'd5);
      latch = 1'b1;
      wait_cyc(10);
      check_eq("abort_bc_load", 32'(bit_count), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd1);
      check_eq("abort_no_fd", 32'(fd_count), 32'(fd_before));
      latch = 1'b0;
      wait_cyc(HALF);
      shift_frame("fabort", 16'h5A3C);
      check_eq("abort_fd_total", 32'(fd_count), 32'(fd_before + 1));

      // Host stalls after 3 pulses
      buttons = 16'hA5C3;
      do_latch(10);
      pulse_n(3);
      check_eq("stall_bc3", 32'(bit_count), 32'd3);
      wait_cyc(300);
`ifdef SNES_RESP_TIMEOUT_EN
      check_eq("stall_busy", 32'(busy), 32'd0);
      check_eq("stall_data", 32'(data), 32'd1);
      check_eq("stall_bc", 32'(bit_count), 32'd0);
`else
      check_eq("stall_busy", 32'(busy), 32'd1);
      check_eq("stall_data", 32'(data), 32'd1);
      check_eq("stall_bc", 32'(bit_count), 32'd3);
`endif
      $display("stall: busy=%0b data=%0b bit_count=%0d", busy, data, bit_count);

      // Asynchronous reset mid-shift clears outputs with no clock edge
      buttons = 16'hA5C3;
      do_latch(10);
      pulse_n(4);
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      check_eq("pre_rst_bc", 32'(bit_count), 32'd4);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("async_rst_data", 32'(data), 32'd1);
      check_eq("async_rst_busy", 32'(busy), 32'd0);
      check_eq("async_rst_fd", 32'(frame_done), 32'd0);
      check_eq("async_rst_bc", 32'(bit_count), 32'd0);
      $display("async reset: data=%0b busy=%0b bit_count=%0d", data, busy, bit_count);
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(HALF);

      // Clean frame after reset
      buttons = 16'h0F0F;
      do_latch(10);
      shift_frame("f0F0F", 16'hF0F0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_snes_pad_responder
